// File: rtl/wrr_arb_pkg.sv
// rtl/wrr_arb_pkg.sv - shared types and helpers for the weighted round-robin bank arbiter
package wrr_arb_pkg;

  // Widest requester vector the helpers handle; callers zero-extend into this width.
  localparam int MAX_REQ = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Binary index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic logic [4:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

  // Bits strictly above the set bit of a one-hot vector; all zero for an all-zero vector.
  function automatic logic [MAX_REQ-1:0] thermo_above(input logic [MAX_REQ-1:0] onehot);
    logic [MAX_REQ-1:0] at_or_below;
    at_or_below = onehot | (onehot - MAX_REQ'(1));
    return ~at_or_below;
  endfunction

endpackage

// File: rtl/rr_fp_pick.sv
// rtl/rr_fp_pick.sv - combinational masked/unmasked lowest-index-first picker
module rr_fp_pick
  import wrr_arb_pkg::*;
#(
  parameter int NUM_REQ = 5
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [NUM_REQ-1:0] above_mask
);

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] sel;
  logic               found;

  // Prefer requesters at or above the pointer; fall back to the full set when none are there.
  always_comb begin
    masked     = req & mask;
    sel        = (|masked) ? masked : req;
    gnt_onehot = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i] && !found) begin
        gnt_onehot[i] = 1'b1;
        found         = 1'b1;
      end
    end
    above_mask = NUM_REQ'(thermo_above(MAX_REQ'(gnt_onehot)));
  end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// rtl/wrr_burst_arbiter.sv - weighted round-robin bank arbiter with burst hold and bank_ready
module wrr_burst_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int NUM_REQ  = 5,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight,
  input  logic                         bank_ready,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         gnt_valid,
  output logic [IDX_W-1:0]             gnt_idx,
  output logic                         xfer,
  output logic [NUM_REQ-1:0]           ptr_mask,
  output logic [WEIGHT_W-1:0]          burst_cnt
);

  localparam logic [NUM_REQ-1:0] ALL_ONES = '1;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic [WEIGHT_W-1:0] wt_q, wt_d;
  logic [NUM_REQ-1:0]  mask_q, mask_d;
  // Bits above the current owner, captured at grant time so release needs no extra decode.
  logic [NUM_REQ-1:0]  above_q, above_d;

  logic                owner_req;
  logic                xfer_c;
  logic                last_beat;
  logic                release_c;
  logic [NUM_REQ-1:0]  rel_mask;
  logic [NUM_REQ-1:0]  others;
  logic [NUM_REQ-1:0]  pick_req;
  logic [NUM_REQ-1:0]  pick_mask;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [NUM_REQ-1:0]  pick_above;
  logic [IDX_W-1:0]    win_idx;
  logic [WEIGHT_W-1:0] win_w;
  logic [WEIGHT_W-1:0] win_w_eff;

  assign owner_req = |(req & gnt_q);
  assign xfer_c    = (|gnt_q) & owner_req & bank_ready;
  assign last_beat = ({1'b0, cnt_q} + (WEIGHT_W+1)'(1)) == {1'b0, wt_q};
  assign release_c = (state_q == GRANT) & (~owner_req | (xfer_c & last_beat));

  // An owner at the top index leaves no bits above it, which means wrap to full priority.
  assign rel_mask  = (|above_q) ? above_q : ALL_ONES;

  // On release the owner competes only when nobody else asks, so it is re-granted as sole requester.
  assign others    = req & ~gnt_q;
  assign pick_req  = (state_q == GRANT) ? ((|others) ? others : req) : req;
  assign pick_mask = (state_q == GRANT) ? rel_mask : mask_q;

  rr_fp_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (pick_req),
    .mask       (pick_mask),
    .gnt_onehot (pick_gnt),
    .above_mask (pick_above)
  );

  assign win_idx   = IDX_W'(onehot_to_idx(MAX_REQ'(pick_gnt)));
  assign win_w     = weight[int'(win_idx)*WEIGHT_W +: WEIGHT_W];
  assign win_w_eff = (win_w == '0) ? WEIGHT_W'(1) : win_w;

  // Next-state: grant from IDLE, count beats, and hand over to the next owner without a bubble.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wt_d    = wt_q;
    mask_d  = mask_q;
    above_d = above_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = pick_gnt;
          idx_d   = win_idx;
          cnt_d   = '0;
          wt_d    = win_w_eff;
          above_d = pick_above;
        end
      end
      GRANT: begin
        if (release_c) begin
          mask_d = rel_mask;
          cnt_d  = '0;
          if (|pick_gnt) begin
            gnt_d   = pick_gnt;
            idx_d   = win_idx;
            wt_d    = win_w_eff;
            above_d = pick_above;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            wt_d    = '0;
            above_d = '0;
          end
        end else if (xfer_c) begin
          cnt_d = cnt_q + WEIGHT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
        wt_d    = '0;
        above_d = '0;
      end
    endcase
  end

  // State and grant registers; reset wins over any in-flight burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wt_q    <= '0;
      mask_q  <= ALL_ONES;
      above_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wt_q    <= wt_d;
      mask_q  <= mask_d;
      above_q <= above_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_idx   = idx_q;
  assign xfer      = xfer_c;
  assign ptr_mask  = mask_q;
  assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// tb/tb_wrr_burst_arbiter.sv - self-checking bench for wrr_burst_arbiter
module tb_wrr_burst_arbiter;

  localparam int N  = 5;
  localparam int WW = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*WW-1:0] weight = '0;
  logic            bank_ready = 1'b1;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [IW-1:0]   gnt_idx;
  logic            xfer;
  logic [N-1:0]    ptr_mask;
  logic [WW-1:0]   burst_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner index (-1 = none), beats taken, next-priority position, burst length.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  int m_wt    = 0;

  logic [N-1:0]  e_gnt;
  logic          e_valid;
  logic [IW-1:0] e_idx;
  logic          e_xfer;
  logic [N-1:0]  e_mask;
  logic [WW-1:0] e_cnt;

  wrr_burst_arbiter #(
    .NUM_REQ  (N),
    .WEIGHT_W (WW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .weight     (weight),
    .bank_ready (bank_ready),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .xfer       (xfer),
    .ptr_mask   (ptr_mask),
    .burst_cnt  (burst_cnt)
  );

  always #5 clk = ~clk;

  function automatic int m_pick(input logic [N-1:0] r, input int p);
    for (int i = p; i < N; i++) if (r[i]) return i;
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic int eff_w(input int i);
    int w;
    w = int'(weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic compute_exp();
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    e_valid = (m_owner >= 0);
    e_idx   = (m_owner >= 0) ? IW'(m_owner) : '0;
    e_xfer  = (m_owner >= 0) && req[m_owner] && bank_ready;
    e_mask  = '1;
    for (int i = 0; i < m_ptr; i++) e_mask[i] = 1'b0;
    e_cnt   = WW'(m_cnt);
  endtask

  task automatic model_step();
    logic [N-1:0] others;
    logic         x;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_wt = 0;
      return;
    end
    if (m_owner < 0) begin
      if (req != '0) begin
        m_owner = m_pick(req, m_ptr);
        m_cnt   = 0;
        m_wt    = eff_w(m_owner);
      end
    end else begin
      x = req[m_owner] && bank_ready;
      if (!req[m_owner] || (x && (m_cnt + 1 == m_wt))) begin
        others = req;
        others[m_owner] = 1'b0;
        m_ptr = (m_owner == N-1) ? 0 : m_owner + 1;
        if (others != '0)      m_owner = m_pick(others, m_ptr);
        else if (!req[m_owner]) m_owner = -1;
        m_cnt = 0;
        m_wt  = (m_owner >= 0) ? eff_w(m_owner) : 0;
      end else if (x) begin
        m_cnt++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rs, input logic [N-1:0] r, input logic br);
    @(negedge clk);
    rst = rs; req = r; bank_ready = br;
    #1;
    compute_exp();
  endtask

  task automatic test_reset();
    drive(1'b1, '0, 1'b1); tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, 1'b1);
      n_checks++; if (gnt !== 5'b00000) begin n_errors++; $display("FAIL reset_gnt: got %b want %b", gnt, 5'b00000); end
      n_checks++; if (gnt_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
      n_checks++; if (ptr_mask !== 5'b11111) begin n_errors++; $display("FAIL reset_mask: got %b want %b", ptr_mask, 5'b11111); end
      n_checks++; if (burst_cnt !== 4'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", burst_cnt); end
      n_checks++; if (gnt_idx !== 3'd0) begin n_errors++; $display("FAIL reset_idx: got %0d want 0", gnt_idx); end
      tick();
    end
  endtask

  task automatic test_rr_weight1();
    int own[5];
    logic [N-1:0] msk[5];
    own = '{0, 2, 4, 0, 2};
    msk = '{5'b11111, 5'b11110, 5'b11000, 5'b11111, 5'b11110};
    weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    drive(1'b1, '0, 1'b1); tick();
    drive(1'b0, 5'b10101, 1'b1);
    n_checks++; if (gnt_valid !== 1'b0) begin n_errors++; $display("FAIL rr_latency: got %b want 0", gnt_valid); end
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 5'b10101, 1'b1);
      n_checks++; if (gnt !== (5'(1) << own[k])) begin n_errors++; $display("FAIL rr_gnt[%0d]: got %b want owner %0d", k, gnt, own[k]); end
      n_checks++; if (gnt_idx !== 3'(own[k])) begin n_errors++; $display("FAIL rr_idx[%0d]: got %0d want %0d", k, gnt_idx, own[k]); end
      n_checks++; if (ptr_mask !== msk[k]) begin n_errors++; $display("FAIL rr_mask[%0d]: got %b want %b", k, ptr_mask, msk[k]); end
      n_checks++; if (xfer !== 1'b1) begin n_errors++; $display("FAIL rr_xfer[%0d]: got %b want 1", k, xfer); end
      tick();
    end
  endtask

  task automatic test_weighted_burst();
    int own[8];
    int cnt[8];
    own = '{0, 0, 0, 1, 1, 0, 0, 0};
    cnt = '{0, 1, 2, 0, 1, 0, 1, 2};
    weight = {4'd1, 4'd1, 4'd1, 4'd2, 4'd3};
    drive(1'b1, '0, 1'b1); tick();
    drive(1'b0, 5'b00011, 1'b1); tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 5'b00011, 1'b1);
      n_checks++; if (gnt !== (5'(1) << own[k])) begin n_errors++; $display("FAIL burst_gnt[%0d]: got %b want owner %0d", k, gnt, own[k]); end
      n_checks++; if (burst_cnt !== 4'(cnt[k])) begin n_errors++; $display("FAIL burst_cnt[%0d]: got %0d want %0d", k, burst_cnt, cnt[k]); end
      tick();
    end
  endtask

  task automatic test_bank_stall();
    weight = {4'd1, 4'd1, 4'd1, 4'd4, 4'd1};
    drive(1'b1, '0, 1'b1); tick();
    drive(1'b0, 5'b00010, 1'b1); tick();
    drive(1'b0, 5'b00010, 1'b1);
    n_checks++; if (burst_cnt !== 4'd0) begin n_errors++; $display("FAIL stall_first_cnt: got %0d want 0", burst_cnt); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'b00010, 1'b0);
      n_checks++; if (gnt !== 5'b00010) begin n_errors++; $display("FAIL stall_gnt[%0d]: got %b want 00010", k, gnt); end
      n_checks++; if (burst_cnt !== 4'd1) begin n_errors++; $display("FAIL stall_cnt[%0d]: got %0d want 1", k, burst_cnt); end
      n_checks++; if (xfer !== 1'b0) begin n_errors++; $display("FAIL stall_xfer[%0d]: got %b want 0", k, xfer); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'b00010, 1'b1);
      n_checks++; if (gnt !== 5'b00010) begin n_errors++; $display("FAIL resume_gnt[%0d]: got %b want 00010", k, gnt); end
      n_checks++; if (burst_cnt !== 4'(k + 1)) begin n_errors++; $display("FAIL resume_cnt[%0d]: got %0d want %0d", k, burst_cnt, k + 1); end
      n_checks++; if (xfer !== 1'b1) begin n_errors++; $display("FAIL resume_xfer[%0d]: got %b want 1", k, xfer); end
      tick();
    end
    drive(1'b0, 5'b00010, 1'b1);
    n_checks++; if (burst_cnt !== 4'd0) begin n_errors++; $display("FAIL stall_regrant_cnt: got %0d want 0", burst_cnt); end
    n_checks++; if (ptr_mask !== 5'b11100) begin n_errors++; $display("FAIL stall_regrant_mask: got %b want 11100", ptr_mask); end
    tick();
  endtask

  task automatic test_owner_drop();
    weight = {4'd1, 4'd1, 4'd5, 4'd1, 4'd1};
    drive(1'b1, '0, 1'b1); tick();
    drive(1'b0, 5'b01100, 1'b1); tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 5'b01100, 1'b1);
      n_checks++; if (gnt !== 5'b00100) begin n_errors++; $display("FAIL drop_owner[%0d]: got %b want 00100", k, gnt); end
      n_checks++; if (burst_cnt !== 4'(k)) begin n_errors++; $display("FAIL drop_cnt[%0d]: got %0d want %0d", k, burst_cnt, k); end
      tick();
    end
    drive(1'b0, 5'b01000, 1'b1);
    n_checks++; if (xfer !== 1'b0) begin n_errors++; $display("FAIL drop_xfer: got %b want 0", xfer); end
    tick();
    drive(1'b0, 5'b01000, 1'b1);
    n_checks++; if (gnt !== 5'b01000) begin n_errors++; $display("FAIL drop_gnt: got %b want 01000", gnt); end
    n_checks++; if (burst_cnt !== 4'd0) begin n_errors++; $display("FAIL drop_newcnt: got %0d want 0", burst_cnt); end
    n_checks++; if (ptr_mask !== 5'b11000) begin n_errors++; $display("FAIL drop_mask: got %b want 11000", ptr_mask); end
    tick();
  endtask

  task automatic test_sole_reset();
    weight = {4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
    drive(1'b1, '0, 1'b1); tick();
    drive(1'b0, 5'b10000, 1'b1); tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 5'b10000, 1'b1);
      n_checks++; if (gnt !== 5'b10000) begin n_errors++; $display("FAIL sole_gnt[%0d]: got %b want 10000", k, gnt); end
      n_checks++; if (burst_cnt !== 4'd0) begin n_errors++; $display("FAIL sole_cnt[%0d]: got %0d want 0", k, burst_cnt); end
      n_checks++; if (ptr_mask !== 5'b11111) begin n_errors++; $display("FAIL sole_mask[%0d]: got %b want 11111", k, ptr_mask); end
      tick();
    end
    drive(1'b1, 5'b10000, 1'b1); tick();
    drive(1'b0, 5'b10000, 1'b1);
    n_checks++; if (gnt !== 5'b00000) begin n_errors++; $display("FAIL sole_rst_gnt: got %b want 00000", gnt); end
    n_checks++; if (gnt_valid !== 1'b0) begin n_errors++; $display("FAIL sole_rst_valid: got %b want 0", gnt_valid); end
    n_checks++; if (gnt_idx !== 3'd0) begin n_errors++; $display("FAIL sole_rst_idx: got %0d want 0", gnt_idx); end
    n_checks++; if (ptr_mask !== 5'b11111) begin n_errors++; $display("FAIL sole_rst_mask: got %b want 11111", ptr_mask); end
    tick();
    drive(1'b0, 5'b10000, 1'b1);
    n_checks++; if (gnt !== 5'b10000) begin n_errors++; $display("FAIL sole_resume: got %b want 10000", gnt); end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic         br;
    logic         rs;
    r = '0;
    drive(1'b1, '0, 1'b1); tick();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) weight = (N*WW)'($urandom);
      r  = r ^ (N'($urandom) & N'($urandom));
      br = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 79) == 0);
      drive(rs, r, br);
      n_checks++; if (gnt !== e_gnt) begin n_errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", k, gnt, e_gnt); end
      n_checks++; if (gnt_valid !== e_valid) begin n_errors++; $display("FAIL rand_valid[%0d]: got %b want %b", k, gnt_valid, e_valid); end
      n_checks++; if (gnt_idx !== e_idx) begin n_errors++; $display("FAIL rand_idx[%0d]: got %0d want %0d", k, gnt_idx, e_idx); end
      n_checks++; if (xfer !== e_xfer) begin n_errors++; $display("FAIL rand_xfer[%0d]: got %b want %b", k, xfer, e_xfer); end
      n_checks++; if (ptr_mask !== e_mask) begin n_errors++; $display("FAIL rand_mask[%0d]: got %b want %b", k, ptr_mask, e_mask); end
      n_checks++; if (burst_cnt !== e_cnt) begin n_errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", k, burst_cnt, e_cnt); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rr_weight1();
    test_weighted_burst();
    test_bank_stall();
    test_owner_drop();
    test_sole_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter with burst-hold for one shared-memory bank port in the CGRA.
- Parametrised successor of the single-cycle mask-based RR arbiter. Adds:
  - registered, lockable grants;
  - per-requester burst weights;
  - a bank_ready handshake;
  - back-to-back re-arbitration with no idle bubble.
- Sits between NUM_REQ PE load/store ports and one memory bank controller.

Parameters:
NUM_REQ, 5, number of requesters. Legal range 2..32.
WEIGHT_W, 4, width of each per-requester weight field.
IDX_W, $clog2(NUM_REQ), derived width of the grant index. Never overridden.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
req  input  NUM_REQ  request vector; bit i held high while port i wants the bank
weight  input  NUM_REQ*WEIGHT_W  burst weight of port i in bits [i*WEIGHT_W +: WEIGHT_W]; value 0 behaves as 1
bank_ready  input  1  bank accepts a transfer this cycle
gnt  output  NUM_REQ  registered one-hot grant; all zero when no owner
gnt_valid  output  1  high when gnt is non-zero
gnt_idx  output  IDX_W  binary index of the owner; 0 when gnt_valid is low
xfer  output  1  transfer accepted this cycle: gnt_valid & req[owner] & bank_ready
ptr_mask  output  NUM_REQ  priority mask register; bits at or above the next-priority position are 1 (test visibility)
burst_cnt  output  WEIGHT_W  transfers accepted in the current grant

Behaviour:
Reset:
- gnt=0, gnt_valid=0, gnt_idx=0, burst_cnt=0, ptr_mask=all ones.
- State is IDLE; the latched weight is 0.
- rst dominates everything. Reset mid-burst drops the grant at the same edge; no transfer is counted.

Arbitration function (combinational, internal):
- Masked fixed-priority over req & ptr_mask, lowest index wins.
- If the masked vector is empty, use unmasked fixed-priority over req.
- Result: a one-hot winner plus the thermometer vector of bits strictly above the winner.

States:
- IDLE: gnt_valid=0.
  - If |req: go to GRANT at the next edge.
  - Load gnt=winner, gnt_idx=index, burst_cnt=0.
  - Latch the winner's weight (0 maps to 1).
  - Latency: req to gnt_valid is 1 cycle.
- GRANT, per cycle:
  - xfer=1: burst_cnt increments.
  - Release condition: (xfer and burst_cnt+1 == latched weight), OR req[owner]==0.
  - On release:
    - ptr_mask <= bits strictly above the owner. If the owner is NUM_REQ-1, ptr_mask <= all ones (wrap-around).
    - Re-arbitrate in the same cycle, using the updated ptr_mask, over req with the owner bit cleared.
    - If that set is empty but the owner still requests, the owner is re-granted (sole requester) with burst_cnt=0.
    - If nothing requests, go to IDLE with gnt=0.
    - No bubble between consecutive owners.
- bank_ready low: grant held, burst_cnt frozen, no release on weight.
- Owner drops req while bank_ready is low: release with no count.
- Requests from non-owners never preempt a grant.
- ptr_mask changes only on release. IDLE with no requests leaves it unchanged.
- burst_cnt never wraps: the release compare fires before the count can overflow.

Decomposition:
- Package wrr_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - function onehot_to_idx;
  - function thermo_above(onehot) returning the bits-above mask.
- One sub-module, rr_fp_pick:
  - purely combinational dual masked/unmasked fixed-priority picker;
  - parameter NUM_REQ;
  - ports req, mask, gnt_onehot, above_mask.
- The top module holds the FSM, counters and registers.

Test Plan (NUM_REQ=5, WEIGHT_W=4, bank_ready=1 unless stated):
- Reset, then req=5'b00000 for 5 cycles -> gnt=0, gnt_valid=0, ptr_mask=5'b11111 throughout.
- req=5'b10101 held, all weights 1 -> owners 0,2,4,0,2 on consecutive cycles; first grant 1 cycle after req; ptr_mask after owner 4 = 5'b11111.
- req=5'b00011 held, weight0=3, weight1=2 -> gnt sequence 0,0,0,1,1,0,0,0; burst_cnt runs 0,1,2,0,1,0,...
- Owner 1 with weight1=4, bank_ready low for 3 cycles mid-burst -> gnt stays 5'b00010, burst_cnt frozen at 1, xfer=0; the burst completes 3 transfers after bank_ready returns.
- Owner 2 with weight2=5 drops req after 2 transfers while req[3]=1 -> at the next edge gnt=5'b01000, burst_cnt=0, ptr_mask=5'b11000.
- Sole requester 4 with weight4=0 (treated as 1), then rst pulsed for 1 cycle mid-stream -> gnt=5'b10000 re-granted every cycle; at the reset edge all outputs return to reset values; grant resumes 1 cycle after rst falls.
